mcif_write_eg: RTL

MCIF_WRITE_EG -- requirements
Module: mcif_write_eg

---
 rtl/mcif_write_eg.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mcif_write_eg.sv
// rtl/mcif_write_eg.sv - AXI write-response egress: pairs B responses with per-thread completion queues
module mcif_write_eg (
    input  logic       nvdla_core_clk,
    input  logic       nvdla_core_rstn,
    input  logic       noc2mcif_axi_b_bvalid,
    output logic       noc2mcif_axi_b_bready,
    input  logic [7:0] noc2mcif_axi_b_bid,
    input  logic [1:0] noc2mcif_axi_b_bresp,
    input  logic       cq_rd0_pvld,
    input  logic       cq_rd1_pvld,
    input  logic       cq_rd2_pvld,
    input  logic       cq_rd3_pvld,
    input  logic       cq_rd4_pvld,
    output logic       cq_rd0_prdy,
    output logic       cq_rd1_prdy,
    output logic       cq_rd2_prdy,
    output logic       cq_rd3_prdy,
    output logic       cq_rd4_prdy,
    input  logic [2:0] cq_rd0_pd,
    input  logic [2:0] cq_rd1_pd,
    input  logic [2:0] cq_rd2_pd,
    input  logic [2:0] cq_rd3_pd,
    input  logic [2:0] cq_rd4_pd,
    output logic       mcif2bdma_wr_rsp_complete,
    output logic       mcif2sdp_wr_rsp_complete,
    output logic       mcif2pdp_wr_rsp_complete,
    output logic       mcif2cdp_wr_rsp_complete,
    output logic       mcif2rbk_wr_rsp_complete,
    output logic       eg2ig_axi_vld,
    output logic [1:0] eg2ig_axi_len,
    output logic       eg_err_bad_id,
    output logic       eg_err_resp
);

    logic [4:0] pvld;
    logic [2:0] pd [5];
    logic [4:0] prdy;
    logic [4:0] complete;

    logic       pipe_vld;
    logic [3:0] pipe_id;
    logic [1:0] pipe_resp;
    logic       pipe_done;
    logic       id_ok;
    logic       pop;
    logic [2:0] pop_pd;
    logic       capture;
    logic       unused_bid_hi;

    assign pvld  = {cq_rd4_pvld, cq_rd3_pvld, cq_rd2_pvld, cq_rd1_pvld, cq_rd0_pvld};
    assign pd[0] = cq_rd0_pd;
    assign pd[1] = cq_rd1_pd;
    assign pd[2] = cq_rd2_pd;
    assign pd[3] = cq_rd3_pd;
    assign pd[4] = cq_rd4_pd;

    // Upper ID bits carry no thread information.
    assign unused_bid_hi = ^noc2mcif_axi_b_bid[7:4];

    assign id_ok = (pipe_id <= 4'd4);

    always_comb begin
        prdy   = 5'b0;
        pop_pd = 3'b0;
        for (int k = 0; k < 5; k++) begin
            prdy[k] = pipe_vld && (pipe_id == 4'(k)) && pvld[k];
            if (prdy[k]) begin
                pop_pd = pd[k];
            end
        end
    end

    // Out-of-range IDs retire immediately so a bad ID can never wedge the pipe.
    assign pop       = |prdy;
    assign pipe_done = pipe_vld && (!id_ok || pop);
    assign noc2mcif_axi_b_bready = !pipe_vld || pipe_done;
    assign capture   = noc2mcif_axi_b_bvalid && noc2mcif_axi_b_bready;

    assign cq_rd0_prdy = prdy[0];
    assign cq_rd1_prdy = prdy[1];
    assign cq_rd2_prdy = prdy[2];
    assign cq_rd3_prdy = prdy[3];
    assign cq_rd4_prdy = prdy[4];

    assign mcif2bdma_wr_rsp_complete = complete[0];
    assign mcif2sdp_wr_rsp_complete  = complete[1];
    assign mcif2pdp_wr_rsp_complete  = complete[2];
    assign mcif2cdp_wr_rsp_complete  = complete[3];
    assign mcif2rbk_wr_rsp_complete  = complete[4];

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            pipe_vld      <= 1'b0;
            pipe_id       <= 4'b0;
            pipe_resp     <= 2'b0;
            complete      <= 5'b0;
            eg2ig_axi_vld <= 1'b0;
            eg2ig_axi_len <= 2'b0;
            eg_err_bad_id <= 1'b0;
            eg_err_resp   <= 1'b0;
        end else begin
            if (capture) begin
                pipe_vld  <= 1'b1;
                pipe_id   <= noc2mcif_axi_b_bid[3:0];
                pipe_resp <= noc2mcif_axi_b_bresp;
            end else if (pipe_done) begin
                pipe_vld  <= 1'b0;
            end
            eg2ig_axi_vld <= pop;
            if (pop) begin
                eg2ig_axi_len <= pop_pd[2:1];
            end
            complete <= prdy & {5{pop_pd[0]}};
            if (pipe_done && !id_ok) begin
                eg_err_bad_id <= 1'b1;
            end
            if (pipe_done && (pipe_resp != 2'b0)) begin
                eg_err_resp <= 1'b1;
            end
        end
    end

endmodule
